// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package sevenseg_pkg;

  localparam int CODE_W     = 5;
  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = 3;

  localparam logic [CODE_W-1:0] BLANK_CODE = 5'h13;

  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Host-write and display-drive signal bundle for sevenseg_scan_ctrl.
interface sevenseg_if;
  import sevenseg_pkg::*;

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic [CODE_W-1:0]     wr_data;
  logic                  wr_dp;
  logic                  commit;
  logic [MAX_DIGITS-1:0] digit_mask;

  logic [CODE_W-1:0]     code_out;
  logic                  dp_n;
  logic [MAX_DIGITS-1:0] an_n;
  logic                  frame_start;
  logic                  commit_ack;

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, commit, digit_mask,
    input  code_out, dp_n, an_n, frame_start, commit_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, commit, digit_mask,
    output code_out, dp_n, an_n, frame_start, commit_ack
  );

endinterface

// File: rtl/sevenseg_phase_timer.sv
// Self-reloading down-counter timing one scan phase of load_val cycles; done marks the last cycle.
module sevenseg_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Zero means "phase just started": the first enabled cycle picks up load_val.
  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (en) begin
      if ((cnt_q == W'(1)) || ((cnt_q == '0) && (load_val <= W'(1)))) begin
        done  = 1'b1;
        cnt_d = '0;
      end else if (cnt_q == '0) begin
        cnt_d = load_val - W'(1);
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Double-buffered 8-digit seven-segment scan controller with guard interval between digits.
// Optional leading-zero suppression is enabled by defining SEVENSEG_LZ_BLANK_EN.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  sevenseg_if.slave  bus
);

  localparam int               TMR_W       = $clog2(max_int(REFRESH_DIV, GUARD_CYCLES) + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam state_e           RESET_STATE = (GUARD_CYCLES == 0) ? ON : GUARD;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [CODE_W-1:0]     act_code_q [MAX_DIGITS];
  logic [CODE_W-1:0]     act_code_d [MAX_DIGITS];
  logic [CODE_W-1:0]     sh_code_q  [MAX_DIGITS];
  logic [CODE_W-1:0]     sh_code_d  [MAX_DIGITS];
  logic [MAX_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [MAX_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [CODE_W-1:0]     code_out_q, code_out_d;
  logic                  dp_n_q, dp_n_d;
  logic [MAX_DIGITS-1:0] an_n_q, an_n_d;
  logic                  fs_q, fs_d;
  logic                  ack_q, ack_d;

  logic                  phase_done;
  logic [TMR_W-1:0]      tmr_load;
  logic                  wrap;

  assign tmr_load = (state_q == GUARD) ? TMR_W'(GUARD_CYCLES) : TMR_W'(REFRESH_DIV);

  sevenseg_phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .en       (1'b1),
    .load_val (tmr_load),
    .done     (phase_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RESET_STATE;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      act_code_q <= '{default: BLANK_CODE};
      sh_code_q  <= '{default: BLANK_CODE};
      act_dp_q   <= '0;
      sh_dp_q    <= '0;
      code_out_q <= BLANK_CODE;
      dp_n_q     <= 1'b1;
      an_n_q     <= '1;
      fs_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      act_code_q <= act_code_d;
      sh_code_q  <= sh_code_d;
      act_dp_q   <= act_dp_d;
      sh_dp_q    <= sh_dp_d;
      code_out_q <= code_out_d;
      dp_n_q     <= dp_n_d;
      an_n_q     <= an_n_d;
      fs_q       <= fs_d;
      ack_q      <= ack_d;
    end
  end

  // Next state: phase sequencing, frame-boundary commit and shadow writes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    act_code_d = act_code_q;
    act_dp_d   = act_dp_q;
    sh_code_d  = sh_code_q;
    sh_dp_d    = sh_dp_q;
    fs_d       = 1'b0;
    ack_d      = 1'b0;
    wrap       = 1'b0;

    if (phase_done) begin
      if (state_q == GUARD) begin
        state_d = ON;
      end else begin
        state_d = (GUARD_CYCLES == 0) ? ON : GUARD;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end

    if (wrap) begin
      fs_d = 1'b1;
      if (pend_q || bus.commit) begin
        act_code_d = sh_code_q;
        act_dp_d   = sh_dp_q;
        ack_d      = 1'b1;
        pend_d     = 1'b0;
      end
    end else if (bus.commit) begin
      pend_d = 1'b1;
    end

    // Shadow update uses the pre-edge copy above, so a write here waits for the next commit.
    if (bus.wr_en && (int'(bus.wr_addr) < NUM_DIGITS)) begin
      sh_code_d[bus.wr_addr] = bus.wr_data;
      sh_dp_d[bus.wr_addr]   = bus.wr_dp;
    end
  end

  // Outputs follow the next state so code, dp and anodes change on the same edge.
  always_comb begin
`ifdef SEVENSEG_LZ_BLANK_EN
    logic lead;
`endif
    code_out_d = act_code_d[idx_d];
    dp_n_d     = ~act_dp_d[idx_d];
    an_n_d     = '1;
    if ((state_d == ON) && bus.digit_mask[idx_d]) begin
      an_n_d[idx_d] = 1'b0;
    end
`ifdef SEVENSEG_LZ_BLANK_EN
    lead = 1'b1;
    for (int j = 1; j < MAX_DIGITS; j++) begin
      if ((j < NUM_DIGITS) && (j > int'(idx_d)) && bus.digit_mask[j] &&
          (act_code_d[j] != '0) && (act_code_d[j] != BLANK_CODE)) begin
        lead = 1'b0;
      end
    end
    if ((idx_d != '0) && (act_code_d[idx_d] == '0) && lead) begin
      code_out_d = BLANK_CODE;
    end
`endif
  end

  assign bus.code_out    = code_out_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.an_n        = an_n_q;
  assign bus.frame_start = fs_q;
  assign bus.commit_ack  = ack_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with a position-based display model checked every cycle.
module tb_sevenseg_scan_ctrl;
  import sevenseg_pkg::*;

  localparam int R     = 4;
  localparam int G     = 2;
  localparam int N     = 8;
  localparam int SLOT  = R + G;
  localparam int FRAME = N * SLOT;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  sevenseg_if bus ();

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs follow from the cycle position within the frame.
  logic [4:0] m_act [N];
  logic [4:0] m_sh  [N];
  logic       m_act_dp [N];
  logic       m_sh_dp  [N];
  bit         m_pend;
  int         m_tick;
  logic [4:0] e_code;
  logic       e_dp_n;
  logic [7:0] e_an;
  logic       e_fs, e_ack;

  function automatic logic [4:0] shown(input int d);
    logic [4:0] c;
`ifdef SEVENSEG_LZ_BLANK_EN
    bit lead;
`endif
    c = m_act[d];
`ifdef SEVENSEG_LZ_BLANK_EN
    lead = 1'b1;
    for (int j = d + 1; j < N; j++)
      if (bus.digit_mask[j] && !(m_act[j] == 5'h0 || m_act[j] == 5'h13)) lead = 1'b0;
    if (d > 0 && c == 5'h0 && lead) c = 5'h13;
`endif
    return c;
  endfunction

  always @(posedge clk) begin
    int pos, d;
    if (!rstn) begin
      m_tick = 0;
      m_pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_act[i] = 5'h13; m_sh[i] = 5'h13; m_act_dp[i] = 1'b0; m_sh_dp[i] = 1'b0;
      end
      e_fs  = 1'b0;
      e_ack = 1'b0;
    end else begin
      m_tick++;
      e_fs  = ((m_tick % FRAME) == 0);
      e_ack = 1'b0;
      if (e_fs && (m_pend || bus.commit)) begin
        m_act    = m_sh;
        m_act_dp = m_sh_dp;
        e_ack    = 1'b1;
        m_pend   = 1'b0;
      end else if (!e_fs && bus.commit) begin
        m_pend = 1'b1;
      end
      if (bus.wr_en) begin
        m_sh[bus.wr_addr]    = bus.wr_data;
        m_sh_dp[bus.wr_addr] = bus.wr_dp;
      end
    end
    pos  = m_tick % FRAME;
    d    = pos / SLOT;
    e_an = 8'hFF;
    if ((pos % SLOT) >= G && bus.digit_mask[d]) e_an[d] = 1'b0;
    e_code = shown(d);
    e_dp_n = !m_act_dp[d];
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an_n",        bus.an_n,        e_an);
      check("model_code_out",    bus.code_out,    e_code);
      check("model_dp_n",        bus.dp_n,        e_dp_n);
      check("model_frame_start", bus.frame_start, e_fs);
      check("model_commit_ack",  bus.commit_ack,  e_ack);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [4:0] c, input logic dp);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[2:0];
    bus.wr_data = c;
    bus.wr_dp   = dp;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    int i;
    for (i = 0; i < FRAME + 2; i++) begin
      step();
      if (bus.frame_start) break;
    end
    check({tag, "_fs_seen"}, (i < FRAME + 2), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [4:0] lz_exp [N];

  initial begin
    int acks, bad, n, lit;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_dp = 1'b0;
    bus.commit = 1'b0; bus.digit_mask = 8'hFF;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);

    // Reset values, then the first guard/on sequence of digit 0
    check("rst_an_n", bus.an_n, 8'hFF);
    check("rst_code", bus.code_out, 5'h13);
    check("rst_dp_n", bus.dp_n, 1'b1);
    check("rst_fs",   bus.frame_start, 1'b0);
    check("rst_ack",  bus.commit_ack, 1'b0);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("start_an_k%0d", k), bus.an_n, (k < 2) ? 8'hFF : 8'hFE);
      if (k >= 2) check($sformatf("start_code_k%0d", k), bus.code_out, 5'h13);
      step();
    end

    wait_fs("period0");
    n = 0;
    do begin step(); n++; end while (!bus.frame_start && n < 100);
    check("frame_period", n, 48);

    // Commit of shadow[3]=7 becomes visible only after the wrap
    bus.commit = 1'b1;
    wr(3, 5'h7, 1'b0);
    bus.commit = 1'b0;
    step(19);
    check("pre_commit_an", bus.an_n, 8'hF7);
    check("pre_commit_code", bus.code_out, 5'h13);
    wait_fs("commit1");
    check("ack_with_fs", bus.commit_ack, 1'b1);
    step(20);
    check("post_commit_an", bus.an_n, 8'hF7);
    check("post_commit_code", bus.code_out, 5'h7);

    // Write without commit, then a double commit
    wr(1, 5'h5, 1'b1);
    acks = 0; bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (bus.commit_ack) acks++;
      if (bus.an_n == 8'hFD && bus.code_out != 5'h13) bad++;
    end
    check("nocommit_acks", acks, 0);
    check("nocommit_digit1", bad, 0);
    bus.commit = 1'b1; step(); bus.commit = 1'b0; step();
    bus.commit = 1'b1; step(); bus.commit = 1'b0;
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.commit_ack) acks++;
    end
    check("double_commit_acks", acks, 1);
    wait_fs("digit1");
    step(8);
    check("digit1_an", bus.an_n, 8'hFD);
    check("digit1_code", bus.code_out, 5'h5);
    check("digit1_dp_n", bus.dp_n, 1'b0);

    // Masked slot 2 stays dark, period unchanged
    bus.digit_mask = 8'hFB;
    wait_fs("mask");
    bad = 0; lit = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step();
      if (!bus.an_n[2]) bad++;
      if (bus.an_n != 8'hFF) lit++;
      if (i == FRAME) check("mask_period_fs", bus.frame_start, 1'b1);
    end
    check("mask_slot2_lit", bad, 0);
    check("mask_lit_cycles", lit, 28);
    bus.digit_mask = 8'hFF;

    // Reset during digit 5 ON clears banks and pending commit
    bus.commit = 1'b1;
    wr(0, 5'h9, 1'b1);
    bus.commit = 1'b0;
    n = 0;
    while (bus.an_n != 8'hDF && n < 60) begin step(); n++; end
    check("digit5_on_seen", (n < 60), 1);
    rstn = 1'b0;
    step();
    check("midrst_an_n", bus.an_n, 8'hFF);
    check("midrst_code", bus.code_out, 5'h13);
    check("midrst_dp_n", bus.dp_n, 1'b1);
    rstn = 1'b1;
    acks = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.commit_ack) acks++;
      if (bus.code_out != 5'h13) bad++;
    end
    check("midrst_pending_cleared", acks, 0);
    check("midrst_active_blank", bad, 0);
    bus.commit = 1'b1; step(); bus.commit = 1'b0;
    wait_fs("midrst_commit");
    check("midrst_commit_ack", bus.commit_ack, 1'b1);
    check("midrst_shadow_blank", bus.code_out, 5'h13);

    // Leading-zero pattern: digit 2 = 1, all others 0
    for (int d = 0; d < N; d++) begin
      if (d == N - 1) bus.commit = 1'b1;
      wr(d, (d == 2) ? 5'h1 : 5'h0, (d == 2));
    end
    bus.commit = 1'b0;
    for (int d = 0; d < N; d++) lz_exp[d] = (d == 2) ? 5'h1 : 5'h0;
`ifdef SEVENSEG_LZ_BLANK_EN
    for (int d = 3; d < N; d++) lz_exp[d] = 5'h13;
`endif
    wait_fs("lz");
    check("lz_commit_ack", bus.commit_ack, 1'b1);
    for (int d = 0; d < N; d++) begin
      step((d == 0) ? 2 : SLOT);
      check($sformatf("lz_code_d%0d", d), bus.code_out, lz_exp[d]);
      if (d == 2) check("lz_dp_n_d2", bus.dp_n, 1'b0);
    end

    step(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Multiplexed scan controller for the 8-digit seven-segment display.
- Sits directly upstream of the 5-bit-code segment decoder:
  - drives the decoder's code input with the active digit's code;
  - drives the active-low anode enables and decimal point.
- Holds double-buffered digit codes: software writes a shadow bank, then the shadow is committed at a frame boundary (no tearing).
- Inserts a guard interval with all anodes off between digits to prevent ghosting.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (1..8); index width 3 bits.
- REFRESH_DIV, 100000, clk cycles each digit is lit (≥1); 1 kHz per digit at 100 MHz.
- GUARD_CYCLES, 1000, all-anodes-off cycles before each digit (0 = no guard phase).

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- wr_en  in  1  write strobe, shadow bank
- wr_addr  in  3  digit index to write
- wr_data  in  5  digit code (decoder encoding; 5'h13 = blank)
- wr_dp  in  1  decimal point for that digit, 1 = lit
- commit  in  1  request shadow→active copy at next frame boundary
- digit_mask  in  8  1 = digit enabled; bits ≥ NUM_DIGITS ignored
- code_out  out  5  code to the segment decoder input
- dp_n  out  1  active-low decimal point
- an_n  out  8  active-low anode enables
- frame_start  out  1  1-cycle pulse when the scan index wraps to 0
- commit_ack  out  1  1-cycle pulse when the copy occurs

Behaviour:
- Clock and reset: one clock (clk). Reset rstn is synchronous and active-low; it is sampled on clk and overrides everything, including mid-scan.
- Reset values:
  - both banks: code 5'h13, dp 0;
  - an_n = 8'hFF, code_out = 5'h13, dp_n = 1;
  - frame_start = 0, commit_ack = 0;
  - idx = 0, phase counter = 0, commit_pending = 0;
  - state = GUARD, or ON when GUARD_CYCLES = 0.
- All outputs are registered.
- State GUARD:
  - an_n = 8'hFF;
  - code_out/dp_n already show digit idx, so the decoder settles before the anode turns on;
  - after GUARD_CYCLES cycles → ON.
- State ON:
  - an_n[idx] = ~digit_mask[idx]; all other bits 1;
  - after REFRESH_DIV cycles, idx advances (NUM_DIGITS-1 wraps to 0), then → GUARD, or ON directly if GUARD_CYCLES = 0;
  - code_out, dp_n and an_n update in the same edge as the transition.
- Scan period: NUM_DIGITS*(REFRESH_DIV+GUARD_CYCLES) cycles.
- digit_mask is sampled live each cycle; a masked digit keeps its time slot dark.
- Frame boundary = the edge where idx wraps to 0:
  - frame_start pulses;
  - if commit_pending, or commit is high in that same cycle: active ← shadow (pre-edge shadow contents), commit_ack pulses, pending cleared;
  - the new active data is displayed starting with digit 0.
- Writes:
  - wr_en updates shadow[wr_addr] at the edge;
  - wr_addr ≥ NUM_DIGITS is ignored;
  - a write in the copy cycle lands in shadow only and appears after the next commit.
- commit while already pending: no effect.
- Codes 5'h14..5'h1F pass through unchanged.

Optional Feature:
- Macro: SEVENSEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. For idx > 0, code_out = 5'h13 when active[idx] == 5'h0 and every higher enabled digit (idx+1..NUM_DIGITS-1, per digit_mask) is 5'h0 or 5'h13. Digit 0 is never suppressed. dp is unaffected.
- Undefined: code_out = active[idx] always.

Decomposition:
- Package sevenseg_pkg:
  - CODE_W = 5, BLANK_CODE = 5'h13, MAX_DIGITS = 8;
  - state enum {GUARD, ON}.
- One sub-module: sevenseg_phase_timer. It is a loadable down-counter: load value, enable, done pulse. It serves both REFRESH_DIV and GUARD_CYCLES, with width = clog2(max(REFRESH_DIV, GUARD_CYCLES)+1).

Test Plan:
Bench parameters: REFRESH_DIV = 4, GUARD_CYCLES = 2, NUM_DIGITS = 8, digit_mask = 8'hFF.
- Reset, then release → an_n = FF for 2 cycles, then an_n = FE for 4 cycles with code_out = 5'h13. frame_start pulses every 48 cycles.
- Write shadow[3] = 5'h7, commit once → active unchanged until the wrap; commit_ack coincides with frame_start. During the next frame, an_n = F7 shows code_out = 5'h7.
- Write without commit → display unchanged over 3 frames. Second commit while pending → exactly one commit_ack.
- digit_mask = 8'hFB → slot 2 keeps an_n = FF throughout. Other slots are unchanged and the period stays 48 cycles.
- Assert rstn = 0 mid-ON of digit 5 → next edge: an_n = FF, idx = 0, both banks blank, pending cleared.
- With SEVENSEG_LZ_BLANK_EN, active = {0,0,0,0,0,1,0,0} (digit 7..0) → digits 7..3 output 5'h13; digits 2, 1 and 0 output 1, 0 and 0. Without the macro, all eight raw codes appear.
